fpu_issue: RTL and testbench
============================

FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter: fma_latency, default 3, cycles from FMA-class issue to writeback; the legal range is fma_latency >= 2.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 flush  input  1  pipeline flush; kills the pending operation.
REQ-005 issue_valid  input  1  decoded FP operation is present.
REQ-006 issue_fma  input  1  operation is fixed-latency: fadd/fsub/fmul/fmadd/fmsub/fnmadd/fnmsub.
REQ-007 issue_div  input  1  operation is variable-latency: fdiv/fsqrt.
REQ-008 issue_fwren  input  1  operation writes the FP register file.
REQ-009 issue_waddr  input  5  FP destination register.
REQ-010 issue_frden1/2/3  input  1 each  FP source-read enables.
REQ-011 issue_raddr1/2/3  input  5 each  FP source addresses.
REQ-012 exe_ready  input  1  single-cycle pulse: the divide/sqrt unit has finished.
REQ-013 issue_ready  output  1  operation is accepted this cycle.
REQ-014 exe_enable  output  1  launches the accepted operation into execute; equals issue_valid & issue_ready.
REQ-015 stall  output  1  equals issue_valid & ~issue_ready.
REQ-016 wb_valid  output  1  registered; multi-cycle result writes the FP register file this cycle.
REQ-017 wb_waddr  output  5  registered; destination register for wb_valid.
REQ-018 busy  output  1  state is not IDLE.

Function
REQ-019 States: IDLE, FMA, DIV, DRAIN.
REQ-020 IDLE, single-cycle operation (~issue_fma & ~issue_div): accept; the state stays IDLE.
REQ-021 IDLE, issue_fma: accept.
  - Capture pend_waddr and pend_fwren.
  - Load cnt with fma_latency-2.
  - Next state: FMA.
REQ-022 IDLE, issue_div: accept, capture pend_waddr/pend_fwren, next state DIV.
REQ-023 Both issue_fma and issue_div asserted: treat the operation as div.
REQ-024 FMA: cnt decrements each cycle. When cnt==0:
  - wb_valid <= pend_fwren.
  - wb_waddr <= pend_waddr.
  - Next state: IDLE.
  - An FMA operation issued in cycle T therefore shows wb_valid in cycle T+fma_latency.
REQ-025 DIV: while exe_ready=0, the state is held. When exe_ready=1:
  - wb_valid <= pend_fwren.
  - Next state: IDLE.
  - wb_valid is high in the cycle after the exe_ready pulse.
REQ-026 wb_valid is high for exactly one cycle per completed operation; wb_waddr holds its value otherwise.
REQ-027 FMA or DIV: any new fma-class or div-class operation gets issue_ready=0.
REQ-028 FMA or DIV: a single-cycle operation gets issue_ready=1 only when there is no hazard.
  - hazard = pend_fwren & ((frden1 & raddr1==pend_waddr) | (frden2 & raddr2==pend_waddr) | (frden3 & raddr3==pend_waddr) | (issue_fwren & issue_waddr==pend_waddr)).
REQ-029 FMA with cnt==0, or DIV with exe_ready=1: issue_ready=0 for every operation.
  - This keeps the FP write port free for the following wb_valid cycle.
REQ-030 In a cycle where wb_valid=1, an operation with issue_fwren=1 gets issue_ready=0 (write-port conflict).
  - An operation with issue_fwren=0 may issue, per the state rules above.
REQ-031 flush has priority over everything: issue_ready=0 and exe_enable=0 in the flush cycle.
REQ-032 flush in FMA: next state IDLE, wb_valid=0, and the pending result is discarded.
REQ-033 flush in DIV: next state DRAIN, with no writeback.
REQ-034 DRAIN: issue_ready=0 until exe_ready=1, then next state IDLE; wb_valid stays 0.
REQ-035 flush in DRAIN or IDLE: the state is unchanged (IDLE stays IDLE).
REQ-036 An exe_ready pulse in IDLE or FMA is ignored.
REQ-037 At most one multi-cycle operation is outstanding at any time.

Reset
REQ-038 reset=0 at a rising edge sets: state=IDLE, cnt=0, pend_fwren=0, pend_waddr=0, wb_valid=0, wb_waddr=0.
REQ-039 Combinational outputs during reset: issue_ready=0, exe_enable=0, stall=issue_valid, busy=0.
REQ-040 Reset mid-operation (FMA, DIV or DRAIN) abandons the operation with no writeback; a later exe_ready is ignored.

Verification
REQ-041 fma_latency=3; fmadd rd=5 issued at cycle 10 -> busy in cycles 11-12; wb_valid=1, wb_waddr=5 at cycle 13 only.
REQ-042 fdiv rd=7 at cycle 0; exe_ready pulses at cycle 20 -> stall for a queued fdiv in cycles 1-21; wb_valid=1, wb_waddr=7 at cycle 21; the queued fdiv is accepted at cycle 21 only if its issue_fwren=0, otherwise at cycle 22.
REQ-043 During fdiv rd=7: fsgnj rs1=3, rd=4 is accepted immediately; fsgnj rs2=7 stalls; fmv.x.w rs1=7 stalls; fsgnj rd=7 stalls (WAW).
REQ-044 fdiv rd=2, flush at cycle 3, exe_ready at cycle 9 -> state DRAIN in cycles 4-9; issue_ready=0 in cycles 3-9; wb_valid never asserted; accepts resume at cycle 10.
REQ-045 fmul in FMA state, reset=0 for one cycle -> busy=0 next cycle; no wb_valid afterward; issue_ready follows issue_valid in IDLE.
REQ-046 issue_fma=1 and issue_div=1 together in IDLE -> the operation enters DIV and waits for exe_ready.

Source files
------------

// File: rtl/fpu_issue.sv
// FP issue control: accepts decoded FP operations, tracks one outstanding
// multi-cycle operation (fixed-latency FMA or variable-latency divide/sqrt) and times its writeback.
module fpu_issue #(
  parameter int fma_latency = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic       issue_fma,
  input  logic       issue_div,
  input  logic       issue_fwren,
  input  logic [4:0] issue_waddr,
  input  logic       issue_frden1,
  input  logic       issue_frden2,
  input  logic       issue_frden3,
  input  logic [4:0] issue_raddr1,
  input  logic [4:0] issue_raddr2,
  input  logic [4:0] issue_raddr3,
  input  logic       exe_ready,
  output logic       issue_ready,
  output logic       exe_enable,
  output logic       stall,
  output logic       wb_valid,
  output logic [4:0] wb_waddr,
  output logic       busy
);
  localparam int cw = $clog2(fma_latency);

  typedef enum logic [1:0] {IDLE, FMA, DIV, DRAIN} state_t;

  state_t        state;
  logic [cw-1:0] cnt;
  logic          pend_fwren;
  logic [4:0]    pend_waddr;

  logic hazard;
  logic is_multi;
  logic finishing;
  logic port_conflict;

  // A single-cycle op may slip past the pending op only if it neither reads nor rewrites its destination.
  always_comb begin
    hazard = pend_fwren & ((issue_frden1 & (issue_raddr1 == pend_waddr)) |
                           (issue_frden2 & (issue_raddr2 == pend_waddr)) |
                           (issue_frden3 & (issue_raddr3 == pend_waddr)) |
                           (issue_fwren  & (issue_waddr  == pend_waddr)));
    is_multi      = issue_fma | issue_div;
    finishing     = ((state == FMA) && (cnt == '0)) || ((state == DIV) && exe_ready);
    port_conflict = wb_valid & issue_fwren;
  end

  always_comb begin
    issue_ready = 1'b0;
    if (reset && !flush && issue_valid && !port_conflict) begin
      case (state)
        IDLE:     issue_ready = 1'b1;
        FMA, DIV: issue_ready = !finishing && !is_multi && !hazard;
        default:  issue_ready = 1'b0;
      endcase
    end
  end

  assign exe_enable = issue_valid & issue_ready;
  assign stall      = issue_valid & ~issue_ready;
  assign busy       = reset & (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_fwren <= 1'b0;
      pend_waddr <= '0;
      wb_valid   <= 1'b0;
      wb_waddr   <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (exe_enable && is_multi) begin
            pend_waddr <= issue_waddr;
            pend_fwren <= issue_fwren;
            // fma+div together is treated as a divide
            if (issue_div) begin
              state <= DIV;
            end else begin
              state <= FMA;
              cnt   <= cw'(fma_latency - 2);
            end
          end
        end
        FMA: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            wb_valid <= pend_fwren;
            wb_waddr <= pend_waddr;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (flush) begin
            state <= DRAIN;
          end else if (exe_ready) begin
            wb_valid <= pend_fwren;
            wb_waddr <= pend_waddr;
            state    <= IDLE;
          end
        end
        default: begin
          // the flushed divide must still finish before the unit can be reused
          if (!flush && exe_ready) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a cycle-count based model of the issue rules.
module tb_fpu_issue;
  localparam int LAT = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       issue_valid = 1'b0, issue_fma = 1'b0, issue_div = 1'b0, issue_fwren = 1'b0;
  logic [4:0] issue_waddr = '0;
  logic       issue_frden1 = 1'b0, issue_frden2 = 1'b0, issue_frden3 = 1'b0;
  logic [4:0] issue_raddr1 = '0, issue_raddr2 = '0, issue_raddr3 = '0;
  logic       exe_ready = 1'b0;
  logic       issue_ready, exe_enable, stall, wb_valid, busy;
  logic [4:0] wb_waddr;

  fpu_issue #(.fma_latency(LAT)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_fma(issue_fma), .issue_div(issue_div),
    .issue_fwren(issue_fwren), .issue_waddr(issue_waddr),
    .issue_frden1(issue_frden1), .issue_frden2(issue_frden2), .issue_frden3(issue_frden3),
    .issue_raddr1(issue_raddr1), .issue_raddr2(issue_raddr2), .issue_raddr3(issue_raddr3),
    .exe_ready(exe_ready), .issue_ready(issue_ready), .exe_enable(exe_enable),
    .stall(stall), .wb_valid(wb_valid), .wb_waddr(wb_waddr), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: which kind of operation is outstanding and the cycle number its result is due.
  typedef enum {M_IDLE, M_FMA, M_DIV, M_DRAIN} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_done_at = 0;
  logic [4:0] m_dest = '0;
  logic       m_fw = 1'b0;
  logic       m_wbv = 1'b0;
  logic [4:0] m_wba = '0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic model_ready();
    logic reads_pend;
    if (!reset || flush || !issue_valid) return 1'b0;
    if (m_wbv && issue_fwren) return 1'b0;
    case (m_mode)
      M_IDLE: return 1'b1;
      M_FMA, M_DIV: begin
        if (m_mode == M_FMA && cyc == m_done_at - 1) return 1'b0;
        if (m_mode == M_DIV && exe_ready) return 1'b0;
        if (issue_fma || issue_div) return 1'b0;
        reads_pend = m_fw && ((issue_frden1 && issue_raddr1 == m_dest) ||
                              (issue_frden2 && issue_raddr2 == m_dest) ||
                              (issue_frden3 && issue_raddr3 == m_dest) ||
                              (issue_fwren  && issue_waddr  == m_dest));
        return !reads_pend;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic r);
    logic nwbv;
    nwbv = 1'b0;
    if (!reset) begin
      m_mode = M_IDLE; m_fw = 1'b0; m_dest = '0; m_wba = '0;
    end else if (flush) begin
      if (m_mode == M_FMA) m_mode = M_IDLE;
      else if (m_mode == M_DIV) m_mode = M_DRAIN;
    end else begin
      case (m_mode)
        M_IDLE: if (r && (issue_fma || issue_div)) begin
          m_dest = issue_waddr; m_fw = issue_fwren;
          m_mode = issue_div ? M_DIV : M_FMA;
          m_done_at = cyc + LAT;
        end
        M_FMA: if (cyc == m_done_at - 1) begin
          nwbv = m_fw; m_wba = m_dest; m_mode = M_IDLE;
        end
        M_DIV: if (exe_ready) begin
          nwbv = m_fw; m_wba = m_dest; m_mode = M_IDLE;
        end
        default: if (exe_ready) m_mode = M_IDLE;
      endcase
    end
    m_wbv = nwbv;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    logic r;
    #1;
    r = model_ready();
    chk("issue_ready", {7'd0, issue_ready}, {7'd0, r});
    chk("exe_enable", {7'd0, exe_enable}, {7'd0, issue_valid & r});
    chk("stall", {7'd0, stall}, {7'd0, issue_valid & ~r});
    chk("busy", {7'd0, busy}, {7'd0, reset && (m_mode != M_IDLE)});
    model_step(r);
    @(posedge clock);
    #1;
    cyc++;
    chk("wb_valid", {7'd0, wb_valid}, {7'd0, m_wbv});
    if (m_wbv) chk("wb_waddr", {3'd0, wb_waddr}, {3'd0, m_wba});
  endtask

  task automatic op(input logic v, input logic fma, input logic dv, input logic fw, input logic [4:0] wa,
                    input logic f1, input logic [4:0] a1, input logic f2, input logic [4:0] a2);
    issue_valid = v; issue_fma = fma; issue_div = dv; issue_fwren = fw; issue_waddr = wa;
    issue_frden1 = f1; issue_raddr1 = a1; issue_frden2 = f2; issue_raddr2 = a2;
    issue_frden3 = 1'b0; issue_raddr3 = '0;
  endtask

  task automatic nop();
    op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    int k;
    // reset state
    reset = 1'b0;
    op(1, 0, 0, 1, 5'd1, 1, 5'd2, 0, 5'd0);
    tick();
    #1 chk("rst_ready", {7'd0, issue_ready}, 8'd0);
    chk("rst_stall", {7'd0, stall}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    tick();
    chk("rst_wb_valid", {7'd0, wb_valid}, 8'd0);
    chk("rst_wb_waddr", {3'd0, wb_waddr}, 8'd0);
    reset = 1'b1;

    // fmadd rd=5: busy two cycles, writeback on the third
    op(1, 1, 0, 1, 5'd5, 1, 5'd1, 1, 5'd2);
    #1 chk("fma_accept", {7'd0, issue_ready}, 8'd1);
    tick(); nop();
    chk("fma_busy1", {7'd0, busy}, 8'd1);
    tick();
    chk("fma_busy2", {7'd0, busy}, 8'd1);
    chk("fma_no_wb_early", {7'd0, wb_valid}, 8'd0);
    tick();
    chk("fma_wb", {7'd0, wb_valid}, 8'd1);
    chk("fma_wb_addr", {3'd0, wb_waddr}, 8'd5);
    chk("fma_idle", {7'd0, busy}, 8'd0);
    tick();
    chk("fma_wb_once", {7'd0, wb_valid}, 8'd0);

    // fdiv rd=7 with a queued fdiv (fwren=1) behind it
    op(1, 0, 1, 1, 5'd7, 1, 5'd1, 1, 5'd2);
    #1 chk("div_accept", {7'd0, issue_ready}, 8'd1);
    tick();
    op(1, 0, 1, 1, 5'd9, 1, 5'd1, 1, 5'd2);
    repeat (3) begin #1 chk("div_queued_stall", {7'd0, stall}, 8'd1); tick(); end
    exe_ready = 1'b1;
    #1 chk("div_done_stall", {7'd0, stall}, 8'd1);
    tick(); exe_ready = 1'b0;
    chk("div_wb", {7'd0, wb_valid}, 8'd1);
    chk("div_wb_addr", {3'd0, wb_waddr}, 8'd7);
    #1 chk("div_port_conflict", {7'd0, stall}, 8'd1);
    tick();
    #1 chk("div_queued_accept", {7'd0, issue_ready}, 8'd1);
    tick();

    // single-cycle ops against pending fdiv rd=9
    op(1, 0, 0, 1, 5'd4, 1, 5'd3, 1, 5'd1);
    #1 chk("indep_accept", {7'd0, issue_ready}, 8'd1);
    tick();
    op(1, 0, 0, 1, 5'd4, 1, 5'd1, 1, 5'd9);
    #1 chk("raw_rs2_stall", {7'd0, stall}, 8'd1);
    tick();
    op(1, 0, 0, 0, 5'd0, 1, 5'd9, 0, 5'd0);
    #1 chk("raw_fmv_stall", {7'd0, stall}, 8'd1);
    tick();
    op(1, 0, 0, 1, 5'd9, 1, 5'd1, 1, 5'd2);
    #1 chk("waw_stall", {7'd0, stall}, 8'd1);
    tick();
    op(1, 0, 1, 0, 5'd0, 1, 5'd1, 1, 5'd2);
    exe_ready = 1'b1;
    #1 chk("div_done_block", {7'd0, issue_ready}, 8'd0);
    tick(); exe_ready = 1'b0;
    chk("div2_wb_addr", {3'd0, wb_waddr}, 8'd9);
    #1 chk("nofw_in_wb_cycle", {7'd0, issue_ready}, 8'd1);
    tick(); nop();
    exe_ready = 1'b1;
    tick(); exe_ready = 1'b0;
    chk("div_nofw_no_wb", {7'd0, wb_valid}, 8'd0);

    // flushed fdiv drains until exe_ready
    op(1, 0, 1, 1, 5'd2, 1, 5'd1, 1, 5'd3);
    tick();
    flush = 1'b1;
    op(1, 0, 0, 1, 5'd20, 1, 5'd21, 1, 5'd22);
    #1 chk("flush_block", {7'd0, issue_ready}, 8'd0);
    tick(); flush = 1'b0;
    chk("drain_busy", {7'd0, busy}, 8'd1);
    repeat (3) begin #1 chk("drain_block", {7'd0, issue_ready}, 8'd0); tick(); end
    exe_ready = 1'b1;
    #1 chk("drain_done_block", {7'd0, issue_ready}, 8'd0);
    tick(); exe_ready = 1'b0;
    chk("drain_no_wb", {7'd0, wb_valid}, 8'd0);
    chk("drain_idle", {7'd0, busy}, 8'd0);
    #1 chk("drain_resume", {7'd0, issue_ready}, 8'd1);
    tick();

    // reset during FMA abandons it
    op(1, 1, 0, 1, 5'd6, 1, 5'd1, 1, 5'd2);
    tick();
    reset = 1'b0;
    op(1, 0, 0, 1, 5'd20, 1, 5'd21, 0, 5'd0);
    #1 chk("rstfma_ready", {7'd0, issue_ready}, 8'd0);
    chk("rstfma_busy", {7'd0, busy}, 8'd0);
    tick(); reset = 1'b1;
    chk("rstfma_busy_after", {7'd0, busy}, 8'd0);
    #1 chk("rstfma_ready_after", {7'd0, issue_ready}, 8'd1);
    tick(); nop();
    repeat (3) begin tick(); chk("rstfma_no_wb", {7'd0, wb_valid}, 8'd0); end

    // fma+div together behaves as divide
    op(1, 1, 1, 1, 5'd11, 1, 5'd1, 1, 5'd2);
    tick(); nop();
    repeat (4) tick();
    chk("both_waits", {7'd0, busy}, 8'd1);
    chk("both_no_wb", {7'd0, wb_valid}, 8'd0);
    exe_ready = 1'b1;
    tick(); exe_ready = 1'b0;
    chk("both_wb", {7'd0, wb_valid}, 8'd1);
    chk("both_wb_addr", {3'd0, wb_waddr}, 8'd11);
    tick();

    // reset during DIV: a later exe_ready is ignored
    op(1, 0, 1, 1, 5'd12, 0, 5'd0, 0, 5'd0);
    tick(); nop();
    reset = 1'b0;
    tick(); reset = 1'b1;
    exe_ready = 1'b1;
    tick(); exe_ready = 1'b0;
    chk("rstdiv_no_wb", {7'd0, wb_valid}, 8'd0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 39) == 0);
      exe_ready = !flush && ($urandom_range(0, 9) == 0);
      k = $urandom_range(0, 9);
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_fma = (k < 3) || (k == 4);
      issue_div = (k == 3) || (k == 4);
      issue_fwren = ($urandom_range(0, 3) != 0);
      issue_waddr = 5'($urandom_range(0, 7));
      issue_frden1 = $urandom_range(0, 1) != 0;
      issue_frden2 = $urandom_range(0, 1) != 0;
      issue_frden3 = $urandom_range(0, 3) == 0;
      issue_raddr1 = 5'($urandom_range(0, 7));
      issue_raddr2 = 5'($urandom_range(0, 7));
      issue_raddr3 = 5'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
